cam_capture: RTL and testbench



---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_byte_pair.sv | 55 +++++
 rtl/cam_capture.sv | 172 +++++++++++++++++
 tb/tb_cam_capture.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Camera capture shared definitions.
// Holds the capture FSM encoding, RGB444 field widths and the default frame
// geometry. The display path uses the same constants, so both sides agree on
// the pixel format and frame size.
package cam_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SKIP   = 2'd1,
      ST_ACTIVE = 2'd2
   } cap_state_t;

   localparam int RGB_W               = 4;
   localparam int PIX_W               = 3 * RGB_W;
   localparam int DEF_PIX_PER_LINE    = 640;
   localparam int DEF_LINES_PER_FRAME = 480;
   localparam int PIX_CNT_W           = 10;
   localparam int LINE_CNT_W          = 9;
   localparam int SKIP_CNT_W          = 4;

endpackage

// File: rtl/cam_byte_pair.sv
// Pairs DVP bytes into RGB444 pixels.
// Ports:
//   i_clk, i_rstn   pixel clock, async active-low reset
//   i_en            byte valid for pairing (href high, capture active)
//   i_hr_rise       start of an href line, restarts the pixel counter
//   i_data          registered camera byte
//   o_pix_vld       one-cycle strobe, pixel assembled from the last two bytes
//   o_pix           {R, G, B}
//   o_pix_cnt       pixels seen on the current line, saturating
module cam_byte_pair
   import cam_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_en,
   input  logic                 i_hr_rise,
   input  logic [7:0]           i_data,
   output logic                 o_pix_vld,
   output logic [PIX_W-1:0]     o_pix,
   output logic [PIX_CNT_W-1:0] o_pix_cnt
);

   logic             phase;
   logic [RGB_W-1:0] red;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         phase     <= 1'b0;
         red       <= '0;
         o_pix_vld <= 1'b0;
         o_pix     <= '0;
         o_pix_cnt <= '0;
      end else begin
         o_pix_vld <= 1'b0;
         // phase drops whenever href drops, so an odd trailing byte is lost
         if (i_en) begin
            phase <= ~phase;
            if (!phase) begin
               red <= i_data[3:0];
            end else begin
               o_pix_vld <= 1'b1;
               o_pix     <= {red, i_data};
            end
         end else begin
            phase <= 1'b0;
         end

         if (i_hr_rise)
            o_pix_cnt <= '0;
         else if (i_en && phase && o_pix_cnt != '1)
            o_pix_cnt <= o_pix_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cam_capture.sv
// DVP camera capture into the frame FIFO.
// Registers vsync/href/data, waits for configuration plus SKIP_FRAMES whole
// frames, then writes frame-aligned RGB444 pixels into the FIFO.
// Ports:
//   i_clk, i_rstn        camera pixel clock, async active-low reset
//   i_cfg_done           camera configuration complete (level)
//   i_vsync, i_href      DVP sync inputs
//   i_data               DVP byte bus
//   i_full               FIFO full
//   o_wr, o_wdata        FIFO write strobe and pixel
//   o_sof, o_frame_done  captured-frame start / end pulses
//   o_overflow           sticky, pixel dropped on full FIFO
//   o_line_err           sticky, line or frame length mismatch
module cam_capture
   import cam_pkg::*;
#(
   parameter int PIX_PER_LINE    = DEF_PIX_PER_LINE,
   parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
   parameter int SKIP_FRAMES     = 2
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_cfg_done,
   input  logic             i_vsync,
   input  logic             i_href,
   input  logic [7:0]       i_data,
   input  logic             i_full,
   output logic             o_wr,
   output logic [PIX_W-1:0] o_wdata,
   output logic             o_sof,
   output logic             o_frame_done,
   output logic             o_overflow,
   output logic             o_line_err
);

   localparam logic [PIX_CNT_W-1:0]  PIX_N  = PIX_CNT_W'(PIX_PER_LINE);
   localparam logic [LINE_CNT_W-1:0] LINE_N = LINE_CNT_W'(LINES_PER_FRAME);
   localparam logic [SKIP_CNT_W-1:0] SKIP_N = SKIP_CNT_W'(SKIP_FRAMES);

   logic       vs_q, hr_q, vs_p, hv_p;
   logic [7:0] d_q;
   logic       hv, vs_fall, vs_rise, hv_rise, hv_fall;

   cap_state_t            state, state_nxt;
   logic [SKIP_CNT_W-1:0] skip_cnt, skip_nxt;
   logic                  go_active, active;
   logic [LINE_CNT_W-1:0] line_cnt;

   logic                 pix_vld;
   logic [PIX_W-1:0]     pix;
   logic [PIX_CNT_W-1:0] pix_cnt;

   // href during vsync is a protocol violation; masking it here keeps it
   // out of pairing, writes and both counters
   assign hv      = hr_q & ~vs_q;
   assign vs_fall = vs_p & ~vs_q;
   assign vs_rise = ~vs_p & vs_q;
   assign hv_rise = hv & ~hv_p;
   assign hv_fall = ~hv & hv_p;
   assign active  = (state == ST_ACTIVE) && i_cfg_done;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         vs_q <= 1'b0;
         hr_q <= 1'b0;
         d_q  <= '0;
         vs_p <= 1'b0;
         hv_p <= 1'b0;
      end else begin
         vs_q <= i_vsync;
         hr_q <= i_href;
         d_q  <= i_data;
         vs_p <= vs_q;
         hv_p <= hv;
      end
   end

   // skip_cnt counts frames already thrown away; the fall that finds it at
   // SKIP_N starts the first captured frame
   always_comb begin
      state_nxt = state;
      skip_nxt  = skip_cnt;
      go_active = 1'b0;
      if (!i_cfg_done) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt = ST_SKIP;
               skip_nxt  = '0;
            end
            ST_SKIP: begin
               if (vs_fall) begin
                  if (skip_cnt == SKIP_N) begin
                     go_active = 1'b1;
                     state_nxt = ST_ACTIVE;
                  end else begin
                     skip_nxt = skip_cnt + 1'b1;
                  end
               end
            end
            ST_ACTIVE: ;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state    <= ST_IDLE;
         skip_cnt <= '0;
      end else begin
         state    <= state_nxt;
         skip_cnt <= skip_nxt;
      end
   end

   cam_byte_pair u_pair (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_en      (active & hv),
      .i_hr_rise (hv_rise),
      .i_data    (d_q),
      .o_pix_vld (pix_vld),
      .o_pix     (pix),
      .o_pix_cnt (pix_cnt)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         line_cnt     <= '0;
         o_wr         <= 1'b0;
         o_wdata      <= '0;
         o_sof        <= 1'b0;
         o_frame_done <= 1'b0;
         o_overflow   <= 1'b0;
         o_line_err   <= 1'b0;
      end else begin
         o_wr         <= 1'b0;
         o_sof        <= 1'b0;
         o_frame_done <= 1'b0;

         if (vs_fall)
            line_cnt <= '0;
         else if (hv_fall && line_cnt != '1)
            line_cnt <= line_cnt + 1'b1;

         // dropped pixels are still counted; later pixels keep trying
         if (pix_vld) begin
            if (i_full) begin
               o_overflow <= 1'b1;
            end else begin
               o_wr    <= 1'b1;
               o_wdata <= pix;
            end
         end

         if (vs_fall && (go_active || active))
            o_sof <= 1'b1;

         if (vs_rise && active) begin
            o_frame_done <= 1'b1;
            if (line_cnt != LINE_N)
               o_line_err <= 1'b1;
         end

         if (hv_fall && active && pix_cnt != PIX_N)
            o_line_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cam_capture.sv
module tb_cam_capture;

   localparam int PPL  = 16;
   localparam int LPF  = 4;
   localparam int SKIP = 2;

   logic        i_clk = 1'b0;
   logic        i_rstn = 1'b1;
   logic        i_cfg_done = 1'b0;
   logic        i_vsync = 1'b1;
   logic        i_href = 1'b0;
   logic [7:0]  i_data = '0;
   logic        i_full = 1'b0;
   logic        o_wr, o_sof, o_frame_done, o_overflow, o_line_err;
   logic [11:0] o_wdata;

   cam_capture #(.PIX_PER_LINE(PPL), .LINES_PER_FRAME(LPF), .SKIP_FRAMES(SKIP)) dut (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_cfg_done   (i_cfg_done),
      .i_vsync      (i_vsync),
      .i_href       (i_href),
      .i_data       (i_data),
      .i_full       (i_full),
      .o_wr         (o_wr),
      .o_wdata      (o_wdata),
      .o_sof        (o_sof),
      .o_frame_done (o_frame_done),
      .o_overflow   (o_overflow),
      .o_line_err   (o_line_err)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      logic [11:0] d;
      int          c;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int total = 0, bad = 0;
   int n_wr = 0, n_sof = 0, n_fd = 0;
   int e_wr = 0, e_sof = 0, e_fd = 0;
   int full_lo = 0, full_hi = 0;
   int last_edge = 0;
   int w0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: every write must match the oldest expected pixel, in data and cycle
   always @(negedge i_clk) begin
      if (o_sof === 1'b1) n_sof++;
      if (o_frame_done === 1'b1) n_fd++;
      if (o_wr === 1'b1) begin
         n_wr++;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wr_unexpected: got write %0h want none (cycle %0d)", o_wdata, cyc);
         end else begin
            e = q.pop_front();
            chk("wdata", 32'(o_wdata), 32'(e.d));
            chk("wr_cycle", cyc, e.c);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // drive one cycle of inputs, sampled by the DUT at edge last_edge
   task automatic step(input logic vs, input logic hr, input logic [7:0] d);
      @(posedge i_clk);
      #1;
      i_vsync   = vs;
      i_href    = hr;
      i_data    = d;
      last_edge = cyc + 1;
      i_full    = (last_edge >= full_lo && last_edge < full_hi);
   endtask

   task automatic do_reset();
      @(posedge i_clk);
      #3 i_rstn = 1'b0;
      @(posedge i_clk);
      #3 i_rstn = 1'b1;
   endtask

   // one frame: vs fall, nlines lines, vs rise.
   // short_ln: line with PPL-1 pixels plus an odd byte; full_ln: FIFO full
   // window on that line; cfgdrop_ln / rst_ln: interruptions; mid_err: line_err
   // expected just before vs rise (-1 = no check)
   task automatic frame(input bit cap_in, input int nlines, input bit cmode,
                        input int short_ln, input int full_ln, input int cfgdrop_ln,
                        input int rst_ln, input int mid_err);
      bit         cap;
      int         np;
      logic [7:0] b0, b1;
      cap = cap_in;
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      if (cap) e_sof++;
      for (int l = 0; l < nlines; l++) begin
         np = (l == short_ln) ? PPL - 1 : PPL;
         if (l == short_ln) chk("line_err_pre", 32'(o_line_err), 0);
         if (l == full_ln) begin
            full_lo = cyc + 1 + 6;
            full_hi = full_lo + 20;
         end
         for (int k = 0; k < np; k++) begin
            b0 = cmode ? 8'h0A : {4'(l + 5), 4'(k)};
            b1 = cmode ? 8'hBC : 8'(k * 19 + l * 7 + 3);
            step(1'b0, 1'b1, b0);
            step(1'b0, 1'b1, b1);
            if (cap && !(last_edge + 2 >= full_lo && last_edge + 2 < full_hi)) begin
               q.push_back('{d: {b0[3:0], b1}, c: last_edge + 2});
               e_wr++;
            end
            if (l == rst_ln && k == 5) begin
               @(posedge i_clk);
               #3 i_rstn = 1'b0;
               #1 chk("async_rst_outs",
                      32'({o_wr, o_wdata, o_sof, o_frame_done, o_overflow, o_line_err}), 0);
               e_wr -= q.size();
               q.delete();
               @(posedge i_clk);
               #3 i_rstn = 1'b1;
               cap = 1'b0;
            end
         end
         if (l == short_ln) step(1'b0, 1'b1, 8'h55);
         repeat (4) step(1'b0, 1'b0, 8'h00);
         if (l == short_ln) chk("line_err_post", 32'(o_line_err), 1);
         if (l == cfgdrop_ln) begin
            i_cfg_done = 1'b0;
            repeat (4) step(1'b0, 1'b0, 8'h00);
            i_cfg_done = 1'b1;
            cap = 1'b0;
         end
      end
      if (mid_err >= 0) chk("line_err_mid", 32'(o_line_err), 32'(mid_err));
      repeat (5) step(1'b1, 1'b0, 8'h00);
      if (cap) e_fd++;
      full_lo = 0;
      full_hi = 0;
   endtask

   initial begin
      i_cfg_done = 1'b1;
      #1 i_rstn = 1'b0;
      repeat (3) @(posedge i_clk);
      #1 chk("reset_outs", 32'({o_wr, o_wdata, o_sof, o_frame_done, o_overflow, o_line_err}), 0);
      #2 i_rstn = 1'b1;
      repeat (4) step(1'b1, 1'b0, 8'h00);

      // two skipped frames, then two captured constant frames
      frame(0, LPF, 1, -1, -1, -1, -1, -1);
      frame(0, LPF, 1, -1, -1, -1, -1, -1);
      chk("skip_no_wr", n_wr, 0);
      chk("skip_no_sof", n_sof, 0);
      frame(1, LPF, 1, -1, -1, -1, -1, -1);
      frame(1, LPF, 1, -1, -1, -1, -1, -1);
      chk("cap_wr_cnt", n_wr, 2 * PPL * LPF);
      chk("cap_sof_cnt", n_sof, 2);
      chk("cap_fd_cnt", n_fd, 2);
      chk("cap_ovf", 32'(o_overflow), 0);
      chk("cap_lerr", 32'(o_line_err), 0);

      // FIFO full for 20 cycles on line 1: 10 pixels lost
      w0 = n_wr;
      frame(1, LPF, 0, -1, 1, -1, -1, -1);
      chk("full_wr_cnt", n_wr - w0, PPL * LPF - 10);
      chk("full_ovf", 32'(o_overflow), 1);

      // short line with dangling byte
      w0 = n_wr;
      frame(1, LPF, 0, 2, -1, -1, -1, -1);
      chk("short_wr_cnt", n_wr - w0, PPL * LPF - 1);
      frame(1, LPF, 0, -1, -1, -1, -1, -1);
      chk("ovf_sticky", 32'(o_overflow), 1);
      chk("lerr_sticky", 32'(o_line_err), 1);

      do_reset();
      chk("rst_ovf_clr", 32'(o_overflow), 0);
      chk("rst_lerr_clr", 32'(o_line_err), 0);

      // frame one line short
      frame(0, LPF, 0, -1, -1, -1, -1, -1);
      frame(0, LPF, 0, -1, -1, -1, -1, -1);
      frame(1, LPF - 1, 0, -1, -1, -1, -1, 0);
      chk("short_frame_lerr", 32'(o_line_err), 1);
      chk("sof_cnt_a", n_sof, e_sof);
      chk("fd_cnt_a", n_fd, e_fd);

      // cfg_done dropped after line 1 of a captured frame
      do_reset();
      frame(0, LPF, 0, -1, -1, -1, -1, -1);
      frame(0, LPF, 0, -1, -1, -1, -1, -1);
      w0 = n_wr;
      frame(1, LPF, 0, -1, -1, 1, -1, -1);
      chk("cfgdrop_wr_cnt", n_wr - w0, 2 * PPL);
      chk("cfgdrop_fd_cnt", n_fd, e_fd);
      w0 = n_wr;
      frame(0, LPF, 0, -1, -1, -1, -1, -1);
      frame(0, LPF, 0, -1, -1, -1, -1, -1);
      chk("cfgdrop_reskip", n_wr - w0, 0);
      frame(1, LPF, 0, -1, -1, -1, -1, -1);
      chk("cfgdrop_resume", n_wr - w0, PPL * LPF);
      chk("cfgdrop_lerr", 32'(o_line_err), 0);

      // async reset mid-line, then the skip sequence starts over
      frame(1, LPF, 0, -1, -1, -1, 2, -1);
      chk("arst_ovf", 32'(o_overflow), 0);
      w0 = n_wr;
      frame(0, LPF, 0, -1, -1, -1, -1, -1);
      frame(0, LPF, 0, -1, -1, -1, -1, -1);
      chk("arst_reskip", n_wr - w0, 0);
      frame(1, LPF, 0, -1, -1, -1, -1, -1);
      chk("arst_resume", n_wr - w0, PPL * LPF);

      repeat (5) step(1'b1, 1'b0, 8'h00);
      chk("queue_empty", q.size(), 0);
      chk("wr_total", n_wr, e_wr);
      chk("sof_total", n_sof, e_sof);
      chk("fd_total", n_fd, e_fd);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
